// File: rtl/seven_seg_pkg.sv
// Shared types and code constants for the multiplexed seven-segment scanner.
package seven_seg_pkg;

  typedef enum logic {
    LIT = 1'b0,
    GAP = 1'b1
  } state_e;

  localparam logic [3:0] CODE_L         = 4'd10;
  localparam logic [3:0] CODE_E         = 4'd11;
  localparam logic [3:0] CODE_BLANK_MIN = 4'd12;

  function automatic logic is_blank_code(input logic [3:0] code);
    return (code >= CODE_BLANK_MIN);
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Frame write port: one 16-bit frame per accepted wr_en, backpressured by wr_ready.
interface seven_seg_scan_if;

  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_ready;

  modport master (output wr_en, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_data, output wr_ready);

endinterface

// File: rtl/seven_seg_ctrl.sv
// Pure digit-code to segment decode; blanking and anode gating live in the caller.
module seven_seg_ctrl
  import seven_seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [7:0] seg_o
);

  // Active-high segments, bit0 = a ... bit6 = g, bit7 = dp (never lit).
  always_comb begin
    seg_o = 8'h00;
    case (code_i)
      4'd0:    seg_o = 8'h3F;
      4'd1:    seg_o = 8'h06;
      4'd2:    seg_o = 8'h5B;
      4'd3:    seg_o = 8'h4F;
      4'd4:    seg_o = 8'h66;
      4'd5:    seg_o = 8'h6D;
      4'd6:    seg_o = 8'h7D;
      4'd7:    seg_o = 8'h07;
      4'd8:    seg_o = 8'h7F;
      4'd9:    seg_o = 8'h6F;
      CODE_L:  seg_o = 8'h38;
      CODE_E:  seg_o = 8'h79;
      default: seg_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit scanner: LIT/GAP slot timing, double-buffered frame register committed
// at frame end, leading-zero blanking, and anode/segment gating.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int GAP_CYC = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  seven_seg_scan_if.slave         wr_bus,
  input  logic                    blank_lz,
  output logic [7:0]              seg,
  output logic [3:0]              an,
  output logic                    frame_done
);

  localparam int MAX_CYC = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] LIT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pos_q, pos_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;

  logic          slot_end_s;
  logic          frame_end_s;
  logic          accept_s;
  logic [3:0]    code_s;
  logic [3:0]    lz_s;
  logic          lit_s;
  logic [7:0]    dec_seg_s;

  // Slot sequencing; en = 0 holds every counter in place.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    slot_end_s = 1'b0;
    if (en) begin
      case (state_q)
        LIT: begin
          if (cnt_q == LIT_LAST) begin
            state_d = GAP;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d    = LIT;
            cnt_d      = CNT_ZERO;
            pos_d      = pos_q + 2'd1;
            slot_end_s = 1'b1;
          end else begin
            cnt_d      = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = GAP;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
    end
  end

  assign frame_end_s = slot_end_s && (pos_q == 2'd3);
  assign accept_s    = wr_bus.wr_en && !pending_q;

  // Double buffer: a write landing on the commit edge bypasses the shadow.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_end_s) begin
      if (accept_s) begin
        active_d  = wr_bus.wr_data;
        shadow_d  = wr_bus.wr_data;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b0;
      end
    end else if (accept_s) begin
      shadow_d  = wr_bus.wr_data;
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // State, counters and frame buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= GAP;
      cnt_q     <= CNT_ZERO;
      pos_q     <= 2'd0;
      active_q  <= 16'hFFFF;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign code_s = active_q[{pos_q, 2'b00} +: 4];

  // lz_s[p]: code at p and every higher position is zero; position 0 never qualifies.
  always_comb begin
    lz_s    = 4'b0000;
    lz_s[3] = (active_q[15:12] == 4'd0);
    lz_s[2] = lz_s[3] && (active_q[11:8] == 4'd0);
    lz_s[1] = lz_s[2] && (active_q[7:4] == 4'd0);
    lz_s[0] = 1'b0;
  end

  assign lit_s = en && (state_q == LIT) && !is_blank_code(code_s)
                 && !(blank_lz && lz_s[pos_q]);

  seven_seg_ctrl u_ctrl (
    .code_i (code_s),
    .seg_o  (dec_seg_s)
  );

  assign seg             = lit_s ? dec_seg_s : 8'h00;
  assign an              = lit_s ? ~(4'b0001 << pos_q) : 4'b1111;
  assign frame_done      = frame_end_s;
  assign wr_bus.wr_ready = !pending_q;

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter CLK_DIV, default 100000: clk cycles each digit is lit per slot; legal range >=1.
REQ-002 Parameter GAP_CYC, default 1000: clk cycles of all-anodes-off between digits for anti-ghosting; legal range >=1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scan enable; 0 freezes the scan and blanks the display.
REQ-006 wr_en  input  1  write request for a new 4-digit frame.
REQ-007 wr_data  input  16  digit codes; position p uses bits [4p+3:4p].
REQ-008 wr_ready  output  1  high when a write can be accepted.
REQ-009 blank_lz  input  1  leading-zero blanking enable.
REQ-010 seg  output  8  active-high segment pattern, bit0 = segment a, bit7 = dp.
REQ-011 an  output  4  anode enables, active-low, an[p] = position p.
REQ-012 frame_done  output  1  one-cycle pulse on the last cycle of each frame.

Function
REQ-013 FSM states: LIT and GAP; LIT lasts exactly CLK_DIV cycles, GAP lasts exactly GAP_CYC cycles, then the FSM returns to LIT.
REQ-014 Leaving GAP advances position by 1, wrapping 3 -> 0; frame = 4*(CLK_DIV+GAP_CYC) cycles.
REQ-015 In LIT, an drives only an[position] low; in GAP, an = 4'b1111 and seg = 8'h00.
REQ-016 Digit codes: 0-9 decimal, 10 = 'L', 11 = 'E', 12-15 = blank (an = 4'b1111, seg = 8'h00 for that slot).
REQ-017 With blank_lz = 1, position p in {3,2,1} is blanked when the active codes at p and at every higher position are 0; position 0 is never leading-zero blanked.
REQ-018 seg and an are combinational functions of registered state only (FSM state, position, active register, blank_lz); there is no path from wr_en or wr_data.
REQ-019 Double buffering: an accepted write (wr_en & wr_ready) loads a shadow register and sets pending; wr_ready = ~pending.
REQ-020 Commit: on the clock edge ending the final GAP cycle of position 3, shadow is copied to active and pending clears.
REQ-021 A write accepted on that same commit edge goes straight to active (write-through), and pending stays 0.
REQ-022 wr_en while wr_ready = 0 is ignored: no shadow update and no error indication.
REQ-023 frame_done is 1 exactly during the final GAP cycle of position 3, coincident with the commit edge.
REQ-024 With en = 0: FSM, counters, position, and commit hold; an = 4'b1111 and seg = 8'h00; writes are still accepted into shadow; frame_done = 0.
REQ-025 When en returns to 1, the scan resumes from the frozen state and count, with no restart.
REQ-026 Counter widths are $clog2 of the larger of CLK_DIV and GAP_CYC, plus 1; counters must not overflow.

Reset
REQ-027 While rst_n = 0, asynchronously: state = GAP, count = 0, position = 0, active = 16'hFFFF (all blank), shadow = 16'h0000, pending = 0.
REQ-028 Reset output values: an = 4'b1111, seg = 8'h00, wr_ready = 1, frame_done = 0.
REQ-029 A reset asserted mid-slot or mid-write discards pending data; the first lit slot after release is position 1, after GAP_CYC cycles.

Structure
REQ-030 Shared package seven_seg_pkg holds: the state enum (LIT, GAP), code constants CODE_L = 4'd10, CODE_E = 4'd11, CODE_BLANK_MIN = 4'd12.
REQ-031 The block instantiates exactly one seven_seg_ctrl for the digit-to-segment decode; this block owns all blanking and the position gating around it.

Verification (CLK_DIV = 4, GAP_CYC = 1)
REQ-032 Write 16'h1234 after reset, en = 1: committed at the first frame end; the next frame shows an 1110/1101/1011/0111 carrying codes 4/3/2/1, with 4 lit cycles and 1 gap cycle each.
REQ-033 Write 16'h0007 with blank_lz = 1: positions 3, 2, and 1 stay dark; position 0 shows seg = 8'h07. With blank_lz = 0: positions 3, 2, and 1 show seg = 8'h3F.
REQ-034 Write A mid-frame, then write B before the frame end: wr_ready = 0 after A and B is dropped; active = A after the frame end, then wr_ready = 1.
REQ-035 Write 16'hBA50 on the frame_done cycle: active updates on that same edge; the next frame shows 0, 5, L, E with wr_ready held at 1.
REQ-036 Drop en for 7 cycles mid-LIT: an = 4'b1111 throughout; the remaining lit count resumes afterward, and the frame period is extended by exactly 7 cycles.
REQ-037 Assert rst_n = 0 mid-slot with pending = 1: an = 4'b1111 immediately; after release, the display is all blank and wr_ready = 1.
